// File: rtl/cam_pkg.sv
// ---------------------------------------------------------------------------
// cam_pkg
// Shared constants and enumerations for the CAM write-side management logic.
//   CAM_DEPTH     number of CAM entries
//   CAM_KEY_W     key / data width
//   CAM_IDX_W     entry index width (log2 CAM_DEPTH)
//   CAM_ADDR_W    width of the CAM write-address port (upper bits unused)
//   KEY_EMPTY     reserved key value marking an empty entry
// ---------------------------------------------------------------------------
package cam_pkg;

    localparam int CAM_DEPTH  = 16;
    localparam int CAM_KEY_W  = 8;
    localparam int CAM_IDX_W  = 4;
    localparam int CAM_ADDR_W = 8;

    localparam logic [CAM_KEY_W-1:0] KEY_EMPTY = 8'h00;

    typedef enum logic {
        OP_INSERT = 1'b0,
        OP_DELETE = 1'b1
    } op_e;

    // ST_MISS means DUP for an insert and NOTFOUND for a delete.
    typedef enum logic [1:0] {
        ST_OK     = 2'd0,
        ST_MISS   = 2'd1,
        ST_FULL   = 2'd2,
        ST_BADKEY = 2'd3
    } status_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SRCH = 2'd1,
        S_UPD  = 2'd2,
        S_RESP = 2'd3
    } state_e;

endpackage

// File: rtl/cam_update_ctrl_if.sv
// ---------------------------------------------------------------------------
// cam_update_ctrl_if
// Request / response bundle between a requester and cam_update_ctrl.
//   req_valid/req_ready  request handshake
//   req_op               0=insert, 1=delete
//   req_key              key (0x00 reserved)
//   rsp_valid            one-cycle response strobe
//   rsp_status           0=OK, 1=DUP/NOTFOUND, 2=FULL, 3=BADKEY
//   rsp_addr             slot written/cleared or matching slot on DUP
// Modports: master = requester side, slave = controller side.
// ---------------------------------------------------------------------------
interface cam_update_ctrl_if #(
    parameter int KEY_W  = 8,
    parameter int ADDR_W = 4
);
    logic              req_valid;
    logic              req_ready;
    logic              req_op;
    logic [KEY_W-1:0]  req_key;
    logic              rsp_valid;
    logic [1:0]        rsp_status;
    logic [ADDR_W-1:0] rsp_addr;

    modport master (
        output req_valid, req_op, req_key,
        input  req_ready, rsp_valid, rsp_status, rsp_addr
    );

    modport slave (
        input  req_valid, req_op, req_key,
        output req_ready, rsp_valid, rsp_status, rsp_addr
    );
endinterface

// File: rtl/cam_free_slot_enc.sv
// ---------------------------------------------------------------------------
// cam_free_slot_enc
// Combinational lowest-zero priority encoder over the entry valid bitmap.
//   i_valid     DEPTH-bit occupancy bitmap
//   o_free_idx  lowest index whose valid bit is 0 (0 when none free)
//   o_any_free  at least one entry is free
// ---------------------------------------------------------------------------
module cam_free_slot_enc #(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4
) (
    input  logic [DEPTH-1:0]  i_valid,
    output logic [ADDR_W-1:0] o_free_idx,
    output logic              o_any_free
);

    // Scan from the top down so the last hit written is the lowest index.
    always_comb begin
        o_free_idx = '0;
        o_any_free = 1'b0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (!i_valid[i]) begin
                o_free_idx = ADDR_W'(i);
                o_any_free = 1'b1;
            end
        end
    end

endmodule

// File: rtl/cam_update_ctrl.sv
// ---------------------------------------------------------------------------
// cam_update_ctrl
// Write-side manager for a 16-entry, 8-bit CAM. Accepts insert/delete
// requests, probes the CAM search port, allocates the lowest free slot or
// clears the matching slot, and returns one status response per request,
// always 3 cycles after the handshake cycle.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   bus               request/response interface (slave side)
//   o_cam_srch_data   key presented to the CAM search input
//   i_cam_found       CAM match flag (combinational from CAM)
//   i_cam_srch_addr   CAM match index (combinational from CAM)
//   o_cam_wr_en       CAM write strobe, only in UPD
//   o_cam_wr_addr     CAM write address (upper bits 0)
//   o_cam_wr_data     CAM write data (0x00 clears an entry)
//   o_count           number of valid entries, 0..DEPTH
//   o_full, o_empty   occupancy flags
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | ready for a request; latch op/key on handshake
// SRCH  | key on CAM search port; capture qualified hit and index
// UPD   | decide outcome, drive at most one CAM write, update bitmap
// RESP  | rsp_valid high for one cycle with registered status/addr
// ---------------------------------------------------------------------------
module cam_update_ctrl
    import cam_pkg::*;
#(
    parameter int DEPTH      = cam_pkg::CAM_DEPTH,
    parameter int KEY_W      = cam_pkg::CAM_KEY_W,
    parameter int ADDR_W     = cam_pkg::CAM_IDX_W,
    parameter int CAM_ADDR_W = cam_pkg::CAM_ADDR_W
) (
    input  logic                  clk,
    input  logic                  rst,
    cam_update_ctrl_if.slave      bus,
    output logic [KEY_W-1:0]      o_cam_srch_data,
    input  logic                  i_cam_found,
    input  logic [ADDR_W-1:0]     i_cam_srch_addr,
    output logic                  o_cam_wr_en,
    output logic [CAM_ADDR_W-1:0] o_cam_wr_addr,
    output logic [KEY_W-1:0]      o_cam_wr_data,
    output logic [ADDR_W:0]       o_count,
    output logic                  o_full,
    output logic                  o_empty
);

    localparam logic [ADDR_W:0] L_DEPTH = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W:0] L_ONE   = (ADDR_W + 1)'(1);

    state_e            r_state;
    op_e               r_op;
    logic [KEY_W-1:0]  r_key;
    logic              r_hit;
    logic [ADDR_W-1:0] r_hit_addr;
    logic [DEPTH-1:0]  r_valid;
    logic [ADDR_W:0]   r_count;
    logic              r_full;
    logic              r_empty;
    logic              r_rsp_valid;
    status_e           r_rsp_status;
    logic [ADDR_W-1:0] r_rsp_addr;

    logic [ADDR_W-1:0] w_free_idx;
    logic              w_any_free;
    status_e           w_status;
    logic [ADDR_W-1:0] w_rsp_addr;
    logic              w_wr;
    logic [ADDR_W-1:0] w_wr_idx;
    logic [KEY_W-1:0]  w_wr_data;
    logic              w_set;
    logic              w_clr;
    logic              w_wr_go;

    cam_free_slot_enc #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_free_enc (
        .i_valid    (r_valid),
        .o_free_idx (w_free_idx),
        .o_any_free (w_any_free)
    );

    // Outcome of the current request, only consumed in UPD.
    always_comb begin
        w_status   = ST_OK;
        w_rsp_addr = '0;
        w_wr       = 1'b0;
        w_wr_idx   = '0;
        w_wr_data  = '0;
        w_set      = 1'b0;
        w_clr      = 1'b0;
        if (r_key == KEY_W'(KEY_EMPTY)) begin
            w_status = ST_BADKEY;
        end else if (r_op == OP_INSERT) begin
            if (r_hit) begin
                w_status   = ST_MISS;
                w_rsp_addr = r_hit_addr;
            end else if (r_full || !w_any_free) begin
                w_status = ST_FULL;
            end else begin
                w_wr       = 1'b1;
                w_wr_idx   = w_free_idx;
                w_wr_data  = r_key;
                w_rsp_addr = w_free_idx;
                w_set      = 1'b1;
            end
        end else begin
            if (r_hit) begin
                w_wr       = 1'b1;
                w_wr_idx   = r_hit_addr;
                w_rsp_addr = r_hit_addr;
                w_clr      = 1'b1;
            end else begin
                w_status = ST_MISS;
            end
        end
    end

    // Reset overrides an in-flight write in the same cycle.
    assign w_wr_go       = (r_state == S_UPD) && w_wr && !rst;
    assign o_cam_wr_en   = w_wr_go;
    assign o_cam_wr_addr = w_wr_go ? {{(CAM_ADDR_W - ADDR_W){1'b0}}, w_wr_idx} : '0;
    assign o_cam_wr_data = w_wr_go ? w_wr_data : '0;

    assign o_cam_srch_data = r_key;
    assign bus.req_ready   = (r_state == S_IDLE) && !rst;
    assign bus.rsp_valid   = r_rsp_valid;
    assign bus.rsp_status  = r_rsp_status;
    assign bus.rsp_addr    = r_rsp_addr;
    assign o_count         = r_count;
    assign o_full          = r_full;
    assign o_empty         = r_empty;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_op         <= OP_INSERT;
            r_key        <= '0;
            r_hit        <= 1'b0;
            r_hit_addr   <= '0;
            r_valid      <= '0;
            r_count      <= '0;
            r_full       <= 1'b0;
            r_empty      <= 1'b1;
            r_rsp_valid  <= 1'b0;
            r_rsp_status <= ST_OK;
            r_rsp_addr   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_rsp_valid <= 1'b0;
                    if (bus.req_valid) begin
                        r_op    <= op_e'(bus.req_op);
                        r_key   <= bus.req_key;
                        r_state <= S_SRCH;
                    end
                end
                S_SRCH: begin
                    // The CAM match alone is not trusted: stale or empty
                    // entries must be backed by a set valid bit.
                    r_hit      <= i_cam_found && r_valid[i_cam_srch_addr];
                    r_hit_addr <= i_cam_srch_addr;
                    r_state    <= S_UPD;
                end
                S_UPD: begin
                    r_rsp_status <= w_status;
                    r_rsp_addr   <= w_rsp_addr;
                    r_rsp_valid  <= 1'b1;
                    if (w_set) begin
                        r_valid[w_wr_idx] <= 1'b1;
                        r_count           <= r_count + L_ONE;
                        r_full            <= (r_count + L_ONE) == L_DEPTH;
                        r_empty           <= 1'b0;
                    end else if (w_clr) begin
                        r_valid[w_wr_idx] <= 1'b0;
                        r_count           <= r_count - L_ONE;
                        r_full            <= 1'b0;
                        r_empty           <= r_count == L_ONE;
                    end
                    r_state <= S_RESP;
                end
                S_RESP: begin
                    r_rsp_valid <= 1'b0;
                    r_state     <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cam_update_ctrl.sv
// ---------------------------------------------------------------------------
// tb_cam_update_ctrl
// Self-checking bench for cam_update_ctrl with a behavioural CAM attached and
// a slot-table reference model of the expected controller outcomes.
// ---------------------------------------------------------------------------
module tb_cam_update_ctrl;
    import cam_pkg::*;

    logic        clk;
    logic        rst;
    logic [7:0]  cam_srch_data;
    logic        cam_found;
    logic [3:0]  cam_srch_addr;
    logic        cam_wr_en;
    logic [7:0]  cam_wr_addr;
    logic [7:0]  cam_wr_data;
    logic [4:0]  count;
    logic        full;
    logic        empty;

    cam_update_ctrl_if #(.KEY_W(8), .ADDR_W(4)) bus ();

    cam_update_ctrl dut (
        .clk             (clk),
        .rst             (rst),
        .bus             (bus),
        .o_cam_srch_data (cam_srch_data),
        .i_cam_found     (cam_found),
        .i_cam_srch_addr (cam_srch_addr),
        .o_cam_wr_en     (cam_wr_en),
        .o_cam_wr_addr   (cam_wr_addr),
        .o_cam_wr_data   (cam_wr_data),
        .o_count         (count),
        .o_full          (full),
        .o_empty         (empty)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural CAM: cleared by reset, lowest matching index wins.
    logic [7:0] cam_mem [16];

    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 16; i++) cam_mem[i] <= 8'h00;
        end else if (cam_wr_en) begin
            cam_mem[cam_wr_addr[3:0]] <= cam_wr_data;
        end
    end

    always_comb begin
        cam_found     = 1'b0;
        cam_srch_addr = 4'd0;
        for (int i = 15; i >= 0; i--) begin
            if (cam_mem[i] == cam_srch_data) begin
                cam_found     = 1'b1;
                cam_srch_addr = 4'(i);
            end
        end
    end

    // Reference model: which key occupies which slot.
    logic [7:0] m_key [16];
    logic       m_vld [16];
    int         m_count;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp)
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        else
            n_pass++;
    endtask

    task automatic model_clear();
        for (int i = 0; i < 16; i++) begin
            m_key[i] = 8'h00;
            m_vld[i] = 1'b0;
        end
        m_count = 0;
    endtask

    task automatic model_apply(input logic op, input logic [7:0] key,
                               output int st, output int addr,
                               output logic wr, output int wr_addr,
                               output logic [7:0] wr_data);
        int hit_idx;
        int free_idx;
        hit_idx  = -1;
        free_idx = -1;
        for (int i = 0; i < 16; i++) begin
            if (m_vld[i] && m_key[i] == key && hit_idx < 0) hit_idx = i;
            if (!m_vld[i] && free_idx < 0) free_idx = i;
        end
        st = 0; addr = 0; wr = 1'b0; wr_addr = 0; wr_data = 8'h00;
        if (key == 8'h00) begin
            st = 3;
        end else if (op == 1'b0) begin
            if (hit_idx >= 0) begin
                st = 1; addr = hit_idx;
            end else if (m_count == 16) begin
                st = 2;
            end else begin
                wr = 1'b1; wr_addr = free_idx; wr_data = key; addr = free_idx;
                m_vld[free_idx] = 1'b1;
                m_key[free_idx] = key;
                m_count++;
            end
        end else begin
            if (hit_idx >= 0) begin
                wr = 1'b1; wr_addr = hit_idx; wr_data = 8'h00; addr = hit_idx;
                m_vld[hit_idx] = 1'b0;
                m_count--;
            end else begin
                st = 1;
            end
        end
    endtask

    // Full transaction: waits for ready, handshakes, checks every phase.
    task automatic do_req(input logic op, input logic [7:0] key);
        int         guard;
        int         e_st, e_addr, e_wa;
        logic       e_wr;
        logic [7:0] e_wd;
        guard = 0;
        while (!bus.req_ready && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        chk("ready_wait", 32'(guard < 20), 32'd1);
        bus.req_valid = 1'b1;
        bus.req_op    = op;
        bus.req_key   = key;
        @(negedge clk);
        bus.req_valid = 1'b0;
        model_apply(op, key, e_st, e_addr, e_wr, e_wa, e_wd);
        // SRCH
        chk("srch_ready", 32'(bus.req_ready), 32'd0);
        chk("srch_rsp",   32'(bus.rsp_valid), 32'd0);
        chk("srch_wr",    32'(cam_wr_en), 32'd0);
        chk("srch_data",  32'(cam_srch_data), 32'(key));
        @(negedge clk);
        // UPD
        chk("upd_ready",  32'(bus.req_ready), 32'd0);
        chk("upd_rsp",    32'(bus.rsp_valid), 32'd0);
        chk("upd_wr_en",  32'(cam_wr_en), 32'(e_wr));
        chk("upd_wr_addr", 32'(cam_wr_addr), 32'(e_wa));
        chk("upd_wr_data", 32'(cam_wr_data), 32'(e_wd));
        @(negedge clk);
        // RESP
        chk("rsp_valid",  32'(bus.rsp_valid), 32'd1);
        chk("rsp_status", 32'(bus.rsp_status), 32'(e_st));
        chk("rsp_addr",   32'(bus.rsp_addr), 32'(e_addr));
        chk("rsp_wr",     32'(cam_wr_en), 32'd0);
        chk("count",      32'(count), 32'(m_count));
        chk("full",       32'(full), 32'(m_count == 16));
        chk("empty",      32'(empty), 32'(m_count == 0));
        @(negedge clk);
        // back in IDLE
        chk("idle_rsp",   32'(bus.rsp_valid), 32'd0);
        chk("idle_ready", 32'(bus.req_ready), 32'd1);
    endtask

    int pulses;
    int rnd_op;
    int rnd_key;

    initial begin
        bus.req_valid = 1'b0;
        bus.req_op    = 1'b0;
        bus.req_key   = 8'h00;
        model_clear();
        rst = 1'b1;
        repeat (3) @(negedge clk);

        chk("rst_ready",     32'(bus.req_ready), 32'd0);
        chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        chk("rst_count",     32'(count), 32'd0);
        chk("rst_empty",     32'(empty), 32'd1);
        chk("rst_full",      32'(full), 32'd0);
        chk("rst_wr_en",     32'(cam_wr_en), 32'd0);
        chk("rst_srch_data", 32'(cam_srch_data), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_ready", 32'(bus.req_ready), 32'd1);

        // Directed: basic inserts, duplicate, delete and slot reuse.
        do_req(1'b0, 8'h11);
        do_req(1'b0, 8'h22);
        do_req(1'b0, 8'h33);
        do_req(1'b0, 8'h22);
        do_req(1'b1, 8'h22);
        do_req(1'b0, 8'h44);

        // Fill to 16 entries, then FULL / NOTFOUND / BADKEY corners.
        for (int k = 1; k <= 16; k++) do_req(1'b0, 8'(k));
        chk("full_flag", 32'(full), 32'd1);
        do_req(1'b0, 8'h77);
        do_req(1'b1, 8'h99);
        do_req(1'b0, 8'h00);

        // Drain everything, then delete on empty.
        do_req(1'b1, 8'h11);
        do_req(1'b1, 8'h44);
        do_req(1'b1, 8'h33);
        for (int k = 1; k <= 16; k++) do_req(1'b1, 8'(k));
        do_req(1'b1, 8'h55);
        chk("drained_empty", 32'(empty), 32'd1);

        // req_valid held high: one accept every 4 cycles.
        pulses = 0;
        bus.req_valid = 1'b1;
        bus.req_op    = 1'b1;
        bus.req_key   = 8'h66;
        for (int i = 0; i < 12; i++) begin
            chk("hold_ready", 32'(bus.req_ready), 32'((i % 4) == 0));
            if (bus.rsp_valid) pulses++;
            @(negedge clk);
        end
        bus.req_valid = 1'b0;
        chk("hold_pulses", 32'(pulses), 32'd3);
        chk("hold_count",  32'(count), 32'd0);

        // Reset landing in UPD of an insert.
        do_req(1'b0, 8'h5A);
        do_req(1'b0, 8'h5B);
        bus.req_valid = 1'b1;
        bus.req_op    = 1'b0;
        bus.req_key   = 8'h5C;
        @(negedge clk);
        bus.req_valid = 1'b0;
        @(negedge clk);
        chk("pre_rst_wr_en", 32'(cam_wr_en), 32'd1);
        rst = 1'b1;
        #1;
        chk("rst_upd_wr_en", 32'(cam_wr_en), 32'd0);
        @(negedge clk);
        chk("rst_upd_rsp", 32'(bus.rsp_valid), 32'd0);
        @(negedge clk);
        chk("rst_upd_rsp2", 32'(bus.rsp_valid), 32'd0);
        rst = 1'b0;
        model_clear();
        @(negedge clk);
        chk("rel_count", 32'(count), 32'd0);
        chk("rel_empty", 32'(empty), 32'd1);
        chk("rel_ready", 32'(bus.req_ready), 32'd1);
        chk("rel_rsp",   32'(bus.rsp_valid), 32'd0);
        do_req(1'b0, 8'h5C);
        do_req(1'b1, 8'h5A);

        // Randomized traffic over a small key pool so fills and hits happen.
        for (int n = 0; n < 80; n++) begin
            rnd_op  = ($urandom_range(0, 2) == 0) ? 1 : 0;
            rnd_key = ($urandom_range(0, 11) == 0) ? 0 : int'($urandom_range(1, 20));
            do_req(1'(rnd_op), 8'(rnd_key));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/cam_update_ctrl.md
Name: cam_update_ctrl

Overview:
Management front-end that owns the write side of the 16-entry, 8-bit CAM. It accepts insert/delete requests over a valid/ready handshake and probes the CAM search port for duplicates or the key's location. It allocates the lowest free slot, or clears the matching slot, and drives the CAM write port. It returns one status response per request and tracks occupancy with a valid bitmap, so key matches are always qualified.

Parameters:
DEPTH, 16, number of CAM entries
KEY_W, 8, key/data width
ADDR_W, 4, entry index width (log2 DEPTH)
CAM_ADDR_W, 8, width of CAM write-address port (upper bits driven 0)

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
req_valid  in  1  request present
req_ready  out  1  controller can accept request
req_op  in  1  0=insert, 1=delete
req_key  in  KEY_W  key; 0x00 reserved (empty-entry marker)
rsp_valid  out  1  one-cycle response strobe
rsp_status  out  2  0=OK, 1=DUP (insert) / NOTFOUND (delete), 2=FULL, 3=BADKEY
rsp_addr  out  ADDR_W  slot written/cleared, or matching slot on DUP; 0 otherwise
cam_srch_data  out  KEY_W  to CAM search input
cam_found  in  1  from CAM, combinational
cam_srch_addr  in  ADDR_W  from CAM, combinational
cam_wr_en  out  1  CAM write strobe
cam_wr_addr  out  CAM_ADDR_W  CAM write address
cam_wr_data  out  KEY_W  CAM write data
count  out  ADDR_W+1  valid entries, 0..16
full  out  1  count==DEPTH
empty  out  1  count==0

Behaviour:
- One clock, clk. Reset is synchronous and active-high on rst; it is sampled on the clk rising edge only.
- FSM states: IDLE, SRCH, UPD, RESP. All state transitions are unconditional except IDLE, which waits for a handshake.
- IDLE: req_ready=1. When req_valid&&req_ready at edge T, register op_q and key_q, then go to SRCH.
- cam_srch_data = key_q, registered, so it is stable throughout SRCH.
- SRCH (cycle T+1): at the end of the cycle, register hit_q = cam_found && valid[cam_srch_addr], and hit_addr_q. Then go to UPD.
- UPD (cycle T+2): decide the result and drive at most one write cycle, then go to RESP. Decision priority:
  - key_q==0: BADKEY, no write.
  - insert, hit_q: DUP, rsp_addr=hit_addr_q, no write.
  - insert, full: FULL, no write.
  - insert, otherwise: cam_wr_en=1, cam_wr_addr=lowest index with valid==0, cam_wr_data=key_q. Set that valid bit, count+1, status OK.
  - delete, hit_q: cam_wr_en=1, cam_wr_addr=hit_addr_q, cam_wr_data=0x00. Clear that valid bit, count-1, status OK.
  - delete, no hit: NOTFOUND, no write.
- RESP (cycle T+3): rsp_valid=1 for exactly one cycle with registered status/addr, then go to IDLE. A new request is accepted no earlier than T+4.
- Latency is fixed at 3 cycles from handshake to rsp_valid for every outcome, including errors.
- cam_wr_en is asserted only in UPD. cam_wr_addr upper bits are 0. Outside UPD, cam_wr_en=0 and write address/data are 0.
- req_ready=0 in SRCH, UPD and RESP. req_valid held high during busy states is ignored, not queued.
- count, full and empty are registered and update on the edge ending UPD.
- Reset values: state IDLE, valid=0, count=0, full=0, empty=1, rsp_valid=0, rsp_status=0, rsp_addr=0, cam_wr_en=0, cam_wr_addr=0, cam_wr_data=0, cam_srch_data=0. req_ready=0 while rst is high.
- Reset mid-operation: an in-flight request is dropped with no response. If rst coincides with UPD, the CAM write is suppressed (cam_wr_en gated by !rst).
- rst must also reset the CAM, so the CAM contents match the cleared valid bitmap.
- Wrap/boundary rules:
  - Insert with count==16 returns FULL even if the key is new.
  - Delete with count==0 returns NOTFOUND.
  - Deleting and reinserting reuses the lowest freed slot.

Decomposition:
- Shared package cam_pkg holds:
  - CAM_DEPTH, CAM_KEY_W, CAM_ADDR_W constants;
  - the op enum (OP_INSERT, OP_DELETE);
  - the status enum (ST_OK, ST_MISS, ST_FULL, ST_BADKEY), with ST_MISS covering DUP/NOTFOUND;
  - the FSM state enum;
  - the reserved key value KEY_EMPTY=0x00.
- One sub-module, cam_free_slot_enc: combinational lowest-zero priority encoder over the DEPTH-bit valid bitmap. Outputs free_idx[ADDR_W-1:0] and any_free.

Test Plan:
- After reset, insert 0x11, 0x22, 0x33 → each rsp_valid exactly 3 cycles after handshake. Statuses OK with rsp_addr 0, 1, 2; CAM write observed on 0/1/2; count=3.
- Insert 0x22 again → status DUP, rsp_addr=1, no cam_wr_en pulse, count stays 3.
- Delete 0x22 → OK, rsp_addr=1, CAM write addr 1 data 0x00. Then insert 0x44 → OK, rsp_addr=1 (lowest free reused).
- Fill all 16 slots with keys 0x01..0x10 → full=1. Insert 0x77 → FULL. Delete 0x99 → NOTFOUND. Insert key 0x00 → BADKEY, no write.
- Delete on empty controller → NOTFOUND, count 0, empty=1. Hold req_valid high continuously → req_ready low during SRCH/UPD/RESP; exactly one accept per 4 cycles.
- Assert rst during UPD of an insert → no cam_wr_en, no rsp_valid. After release: count=0, empty=1, req_ready=1.
